fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_ifid_reg.sv | 54 +++++
 rtl/fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_fetch_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int PC_W_DEF    = 9;
  localparam int INSTR_W_DEF = 16;

  localparam logic [2:0] HALT_OPCODE = 3'b111;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    HALTED
  } fetch_state_t;

  function automatic logic is_halt(input logic [2:0] opcode);
    return opcode == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: clear drops valid, hold freezes, load captures.
module fetch_ifid_reg
  import fetch_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hold,
  input  logic               clear,
  input  logic               load,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_in,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic               valid_out
);

  logic [INSTR_W-1:0] instr_d, instr_q;
  logic [PC_W-1:0]    pc_d, pc_q;
  logic               valid_d, valid_q;

  // A clear only invalidates the entry; the stale word/pc are left in place.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load && !hold) begin
      instr_d = instr_in;
      pc_d    = pc_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_out = instr_q;
  assign pc_out    = pc_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, synchronous imem addressing, IF/ID register, HALT freeze.
// Optional perf counters (fetch_cnt, squash_cnt) enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    imJump,
  input  logic               imJumpFlag,
  input  logic               Flush1,
  input  logic               stall,
  output logic [PC_W-1:0]    mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic               ifid_valid,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        fetch_cnt,
  output logic [15:0]        squash_cnt
`endif
);

  localparam logic [PC_W-1:0] PC_ONE = 1;

  fetch_state_t    state_d, state_q;
  logic [PC_W-1:0] pc_d, pc_q;
  logic [PC_W-1:0] pend_pc_d, pend_pc_q;
  logic            pend_valid_d, pend_valid_q;
  logic            halted_d, halted_q;
  logic            ifid_load, ifid_clear, ifid_hold;
  logic            stall_eff;
  logic            rdata_is_halt;

  // Stall only matters in RUN; re-issuing pend_pc keeps mem_rdata steady while held.
  assign stall_eff     = stall && (state_q == RUN);
  assign mem_addr      = stall_eff ? pend_pc_q : pc_q;
  assign rdata_is_halt = is_halt(mem_rdata[INSTR_W-1 -: 3]);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    halted_d     = halted_q;
    ifid_load    = 1'b0;
    ifid_clear   = 1'b0;
    ifid_hold    = 1'b0;
    if (imJumpFlag && state_q != FILL) begin
      pc_d         = imJump;
      pend_valid_d = 1'b0;
      ifid_clear   = 1'b1;
      halted_d     = 1'b0;
      state_d      = RUN;
    end else begin
      unique case (state_q)
        FILL: begin
          if (imJumpFlag) begin
            pc_d         = imJump;
            pend_valid_d = 1'b0;
            ifid_clear   = 1'b1;
          end else begin
            pend_pc_d    = pc_q;
            pend_valid_d = !Flush1;
            pc_d         = pc_q + PC_ONE;
            ifid_clear   = Flush1;
          end
          state_d = RUN;
        end
        RUN: begin
          if (Flush1) begin
            ifid_clear   = 1'b1;
            pend_valid_d = 1'b0;
            if (!stall) begin
              pend_pc_d = pc_q;
              pc_d      = pc_q + PC_ONE;
            end
          end else if (stall) begin
            ifid_hold = 1'b1;
          end else if (pend_valid_q && rdata_is_halt) begin
            ifid_load    = 1'b1;
            pend_valid_d = 1'b0;
            halted_d     = 1'b1;
            state_d      = HALTED;
          end else begin
            ifid_load    = pend_valid_q;
            pend_pc_d    = pc_q;
            pend_valid_d = 1'b1;
            pc_d         = pc_q + PC_ONE;
          end
        end
        HALTED: begin
          ifid_hold = 1'b1;
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FILL;
      pc_q         <= RESET_PC;
      pend_pc_q    <= '0;
      pend_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      halted_q     <= halted_d;
    end
  end

  assign halted = halted_q;

  fetch_ifid_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_ifid_reg (
    .clk       (clk),
    .reset     (reset),
    .hold      (ifid_hold),
    .clear     (ifid_clear),
    .load      (ifid_load),
    .instr_in  (mem_rdata),
    .pc_in     (pend_pc_q),
    .instr_out (ifid_instr),
    .pc_out    (ifid_pc),
    .valid_out (ifid_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_d, fetch_cnt_q;
  logic [15:0] squash_cnt_d, squash_cnt_q;
  logic        squash_evt;

  // A squash only counts when a redirect actually discards a live entry.
  assign squash_evt = (imJumpFlag || (Flush1 && state_q != HALTED)) &&
                      (ifid_valid || pend_valid_q);

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (ifid_load && !ifid_clear && !ifid_hold && fetch_cnt_q != 16'hFFFF) begin
      fetch_cnt_d = fetch_cnt_q + 16'd1;
    end
    if (squash_evt && squash_cnt_q != 16'hFFFF) begin
      squash_cnt_d = squash_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle synchronous instruction memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  imJump = '0;
  logic        imJumpFlag = 1'b0;
  logic        Flush1 = 1'b0;
  logic        stall = 1'b0;
  logic [8:0]  mem_addr;
  logic [15:0] mem_rdata = '0;
  logic [15:0] ifid_instr;
  logic [8:0]  ifid_pc;
  logic        ifid_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt;
  logic [15:0] squash_cnt;
`endif

  int errCount = 0;
  int checkCount = 0;

  logic [15:0] mem [0:511];

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .imJump     (imJump),
    .imJumpFlag (imJumpFlag),
    .Flush1     (Flush1),
    .stall      (stall),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .ifid_instr (ifid_instr),
    .ifid_pc    (ifid_pc),
    .ifid_valid (ifid_valid),
    .halted     (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .squash_cnt (squash_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_addr];

  // Drive one cycle's controls, take the rising edge, then settle for sampling.
  task automatic applyStimulus(input logic jf, input logic [8:0] ja,
                               input logic fl, input logic st);
    imJumpFlag = jf;
    imJump     = ja;
    Flush1     = fl;
    stall      = st;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h1000 + 16'(i);

    // Reset state
    applyStimulus(1'b0, 9'h0, 1'b0, 1'b0);
    checkOutput("rst_valid", 32'(ifid_valid), 32'h0);
    checkOutput("rst_pc", 32'(ifid_pc), 32'h0);
    checkOutput("rst_instr", 32'(ifid_instr), 32'h0);
    checkOutput("rst_halted", 32'(halted), 32'h0);
    checkOutput("rst_addr", 32'(mem_addr), 32'h0);
    reset = 1'b0;

    // Sequential fetch from address 0
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b0, 9'h0, 1'b0, 1'b0);
      checkOutput("seq_addr", 32'(mem_addr), 32'(k));
      if (k >= 2) begin
        checkOutput("seq_valid", 32'(ifid_valid), 32'h1);
        checkOutput("seq_pc", 32'(ifid_pc), 32'(k - 2));
        checkOutput("seq_instr", 32'(ifid_instr), 32'h1000 + 32'(k - 2));
      end else begin
        checkOutput("seq_first_valid", 32'(ifid_valid), 32'h0);
      end
    end

    // Stall 3 cycles with ifid_pc=4: pending address 5 is re-issued
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 9'h0, 1'b0, 1'b1);
      checkOutput("stall_pc", 32'(ifid_pc), 32'h4);
      checkOutput("stall_instr", 32'(ifid_instr), 32'h1004);
      checkOutput("stall_addr", 32'(mem_addr), 32'h5);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 9'h0, 1'b0, 1'b0);
      checkOutput("unstall_pc", 32'(ifid_pc), 32'(5 + k));
      checkOutput("unstall_instr", 32'(ifid_instr), 32'h1005 + 32'(k));
      checkOutput("unstall_addr", 32'(mem_addr), 32'(7 + k));
    end

    // Jump to 0x40 while ifid_pc=7
    applyStimulus(1'b1, 9'h040, 1'b0, 1'b0);
    checkOutput("jmp_valid0", 32'(ifid_valid), 32'h0);
    checkOutput("jmp_addr", 32'(mem_addr), 32'h40);
    applyStimulus(1'b0, 9'h0, 1'b0, 1'b0);
    checkOutput("jmp_valid1", 32'(ifid_valid), 32'h0);
    checkOutput("jmp_addr1", 32'(mem_addr), 32'h41);
    applyStimulus(1'b0, 9'h0, 1'b0, 1'b0);
    checkOutput("jmp_tgt_valid", 32'(ifid_valid), 32'h1);
    checkOutput("jmp_tgt_pc", 32'(ifid_pc), 32'h40);
    checkOutput("jmp_tgt_instr", 32'(ifid_instr), 32'h1040);

    // Jump and stall together: jump wins
    applyStimulus(1'b1, 9'h080, 1'b0, 1'b1);
    checkOutput("jmpstl_valid", 32'(ifid_valid), 32'h0);
    imJumpFlag = 1'b0;
    stall = 1'b0;
    #1;
    checkOutput("jmpstl_addr", 32'(mem_addr), 32'h80);
    applyStimulus(1'b0, 9'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 9'h0, 1'b0, 1'b0);
    checkOutput("jmpstl_tgt_pc", 32'(ifid_pc), 32'h80);
    checkOutput("jmpstl_tgt_valid", 32'(ifid_valid), 32'h1);

    // Flush squashes IF/ID and the in-flight fetch of 0x82
    applyStimulus(1'b0, 9'h0, 1'b1, 1'b0);
    checkOutput("fl_valid0", 32'(ifid_valid), 32'h0);
    checkOutput("fl_addr0", 32'(mem_addr), 32'h83);
    applyStimulus(1'b0, 9'h0, 1'b0, 1'b0);
    checkOutput("fl_valid1", 32'(ifid_valid), 32'h0);
    applyStimulus(1'b0, 9'h0, 1'b0, 1'b0);
    checkOutput("fl_resume_pc", 32'(ifid_pc), 32'h83);
    checkOutput("fl_resume_instr", 32'(ifid_instr), 32'h1083);

    // PC wrap from 0x1FF to 0x000
    applyStimulus(1'b1, 9'h1FE, 1'b0, 1'b0);
    checkOutput("wrap_addr0", 32'(mem_addr), 32'h1FE);
    applyStimulus(1'b0, 9'h0, 1'b0, 1'b0);
    checkOutput("wrap_addr1", 32'(mem_addr), 32'h1FF);
    applyStimulus(1'b0, 9'h0, 1'b0, 1'b0);
    checkOutput("wrap_addr2", 32'(mem_addr), 32'h000);
    checkOutput("wrap_pc2", 32'(ifid_pc), 32'h1FE);
    checkOutput("wrap_instr2", 32'(ifid_instr), 32'h11FE);
    applyStimulus(1'b0, 9'h0, 1'b0, 1'b0);
    checkOutput("wrap_addr3", 32'(mem_addr), 32'h001);
    checkOutput("wrap_pc3", 32'(ifid_pc), 32'h1FF);

    // Reset asserted during a stall
    applyStimulus(1'b0, 9'h0, 1'b0, 1'b1);
    reset = 1'b1;
    applyStimulus(1'b0, 9'h0, 1'b0, 1'b1);
    checkOutput("rst2_valid", 32'(ifid_valid), 32'h0);
    checkOutput("rst2_pc", 32'(ifid_pc), 32'h0);
    checkOutput("rst2_instr", 32'(ifid_instr), 32'h0);
    checkOutput("rst2_halted", 32'(halted), 32'h0);
    checkOutput("rst2_addr", 32'(mem_addr), 32'h0);
    reset = 1'b0;
    stall = 1'b0;

    // HALT at address 3
    mem[3] = 16'hE000;
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 9'h0, 1'b0, 1'b0);
    checkOutput("pre_halt_pc", 32'(ifid_pc), 32'h2);
    checkOutput("pre_halt_flag", 32'(halted), 32'h0);
    applyStimulus(1'b0, 9'h0, 1'b0, 1'b0);
    checkOutput("halt_flag", 32'(halted), 32'h1);
    checkOutput("halt_pc", 32'(ifid_pc), 32'h3);
    checkOutput("halt_instr", 32'(ifid_instr), 32'hE000);
    checkOutput("halt_valid", 32'(ifid_valid), 32'h1);
    checkOutput("halt_addr", 32'(mem_addr), 32'h4);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 9'h0, 1'b0, 1'b1);
      checkOutput("halt_hold_addr", 32'(mem_addr), 32'h4);
      checkOutput("halt_hold_pc", 32'(ifid_pc), 32'h3);
      checkOutput("halt_hold_flag", 32'(halted), 32'h1);
    end

    // Jump out of HALTED
    applyStimulus(1'b1, 9'h010, 1'b0, 1'b0);
    checkOutput("unhalt_flag", 32'(halted), 32'h0);
    checkOutput("unhalt_valid", 32'(ifid_valid), 32'h0);
    checkOutput("unhalt_addr", 32'(mem_addr), 32'h10);
    applyStimulus(1'b0, 9'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 9'h0, 1'b0, 1'b0);
    checkOutput("unhalt_pc", 32'(ifid_pc), 32'h10);
    checkOutput("unhalt_instr", 32'(ifid_instr), 32'h1010);
    checkOutput("unhalt_tvalid", 32'(ifid_valid), 32'h1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
